// File: rtl/instruction_fetch.sv
// Instruction fetch stage: IDLE/FETCH/EXEC/HALT sequencer, PC update and imem handshake with ack timeout.
// Define IF_MISALIGN_TRAP_EN to trap misaligned next-PC targets instead of silently aligning them.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_and_zero,
  input  logic        jump,
  input  logic [31:0] branch_offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} fsmState_t;

  fsmState_t   state;
  logic [7:0]  timeoutCnt;
  logic [7:0]  timeoutInc;
  logic [31:0] targetPc;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign opcode      = instr[31:26];
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign timeoutInc  = timeoutCnt + 8'd1;

  // Jump outranks a taken branch; both are relative to pc_plus4.
  always_comb begin
    // NOTE: default assignment first so every path drives targetPc and no latch is inferred.
    targetPc = pc_plus4;
    if (jump)
      targetPc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch_and_zero)
      targetPc = pc_plus4 + (branch_offset << 2);
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr      <= '0;
      timeoutCnt <= '0;
      fetch_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            instr      <= imem_rdata;
            timeoutCnt <= '0;
            state      <= EXEC;
          end else if (timeoutInc == ACK_TIMEOUT) begin
            fetch_err <= 1'b1;
            state     <= HALT;
          end else begin
            timeoutCnt <= timeoutInc;
          end
        end
        EXEC: begin
          if (!stall) begin
`ifdef IF_MISALIGN_TRAP_EN
            if (targetPc[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state     <= HALT;
            end else begin
              pc    <= targetPc;
              state <= FETCH;
            end
`else
            pc    <= {targetPc[31:2], 2'b00};
            state <= FETCH;
`endif
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 8'd255, meaning the maximum cycles to wait for imem_ack before a fetch error.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  downstream not ready; holds the current instruction.
REQ-006 SHALL have port branch_and_zero  input  1  taken-branch flag from the control unit.
REQ-007 SHALL have port jump  input  1  jump flag from the control unit.
REQ-008 SHALL have port branch_offset  input  32  sign-extended immediate, in words.
REQ-009 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-010 SHALL have port imem_addr  output  32  read address; always equals pc.
REQ-011 SHALL have port imem_ack  input  1  read data valid this cycle.
REQ-012 SHALL have port imem_rdata  input  32  instruction word.
REQ-013 SHALL have port instr  output  32  latched instruction.
REQ-014 SHALL have port opcode  output  6  instr[31:26], fed to the control unit.
REQ-015 SHALL have port instr_valid  output  1  instr/opcode valid for execution.
REQ-016 SHALL have port pc  output  32  current PC.
REQ-017 SHALL have port pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-018 SHALL have port fetch_err  output  1  sticky flag for ack timeout or misaligned target.

Function
REQ-019 SHALL implement the FSM states IDLE, FETCH, EXEC and HALT; reset state SHALL be IDLE.
REQ-020 SHALL move IDLE->FETCH unconditionally on the first clk edge after reset deasserts.
REQ-021 SHALL set imem_req = 1 exactly when state is FETCH, decoded from state only.
REQ-022 SHALL, in FETCH on the edge with imem_ack=1, latch imem_rdata into instr, clear the timeout counter, and move to EXEC.
REQ-023 SHALL ignore imem_ack in every state other than FETCH.
REQ-024 SHALL count FETCH cycles without ack with an 8-bit counter; on reaching ACK_TIMEOUT it SHALL set fetch_err and move to HALT.
REQ-025 SHALL set instr_valid = 1 exactly when state is EXEC.
REQ-026 SHALL, in EXEC with stall=1, hold pc, instr and the state.
REQ-027 SHALL, in EXEC with stall=0, load pc with next_pc and move to FETCH.
REQ-028 SHALL sample branch_and_zero and jump only in the EXEC cycle where stall=0.
REQ-029 SHALL select next_pc by priority: jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch_and_zero -> pc_plus4 + (branch_offset << 2), truncated to 32 bits; else pc_plus4.
REQ-030 SHALL wrap all PC arithmetic modulo 2^32 (pc 32'hFFFF_FFFC -> pc_plus4 32'h0000_0000).
REQ-031 SHALL treat HALT as terminal: imem_req=0, instr_valid=0, pc frozen, exit only by reset.
REQ-032 SHALL take a minimum of 2 cycles per instruction (FETCH with immediate ack, then EXEC with stall=0).

Reset
REQ-033 SHALL, on reset assertion, immediately set state=IDLE, pc=RESET_PC, instr=0, timeout counter=0 and fetch_err=0, giving imem_req=0 and instr_valid=0.
REQ-034 SHALL, when reset is asserted mid-FETCH, drop imem_req asynchronously; a later ack SHALL be ignored per REQ-023.

Configuration
REQ-035 SHALL, with IF_MISALIGN_TRAP_EN defined, and a selected next_pc[1:0] != 0 in REQ-027, not load pc, set fetch_err and move to HALT.
REQ-036 SHALL, without IF_MISALIGN_TRAP_EN, force next_pc[1:0] to 2'b00 before loading pc and never raise fetch_err from misalignment.

Verification
REQ-037 SHALL verify: reset, then ack in every FETCH, stall=0, no branch/jump -> pc goes 0,4,8,C; instr_valid high every 2nd cycle.
REQ-038 SHALL verify: pc=32'h10, branch_and_zero=1, branch_offset=32'hFFFF_FFFE -> next pc=32'hC.
REQ-039 SHALL verify: pc=32'h4000_0000, jump=1 and branch_and_zero=1, instr[25:0]=26'h10 -> next pc=32'h4000_0040.
REQ-040 SHALL verify: stall=1 for 3 EXEC cycles -> pc/instr unchanged, imem_req=0; release -> advance one cycle later.
REQ-041 SHALL verify: ACK_TIMEOUT=4, ack never asserted -> fetch_err=1, HALT, imem_req=0; later ack ignored.
REQ-042 SHALL verify: reset pulse mid-FETCH, then ack arriving in IDLE -> pc=RESET_PC, instr=0, imem_req=0 until the next edge.
